branch_target_buffer: RTL and testbench

Tagged, direct-mapped branch target buffer with parametrised depth, tag width and saturating-counter width. It replaces the fixed 4-entry, untagged prediction table. Lookups are combinational from the IF-stage PC. Updates arrive from the resolving stage with the actual outcome. A multi-cycle invalidation sweep clears the table after context switches or self-modifying code.

---
 rtl/branch_target_buffer.sv | 210 +++++++++++++++++++++
 tb/tb_branch_target_buffer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// ---------------------------------------------------------------------------
// branch_target_buffer
//
// Tagged, direct-mapped branch target buffer. The IF stage looks up the
// current PC combinationally; the resolving stage writes back actual branch
// outcomes one per cycle. A flush request starts a multi-cycle sweep that
// invalidates every entry, one per clock.
//
// Optional feature: define BTB_STATS_EN to build the 32-bit saturating
// lookup-hit and mispredict counters. Without it both statistics outputs
// are tied to zero and no counter registers exist.
//
// Ports
//   clk            rising-edge clock
//   arst_n         asynchronous active-low reset
//   IF_PC          lookup PC
//   pred_hit       looked-up entry valid and tag matches (0 while sweeping)
//   pred_taken     pred_hit & counter MSB
//   pred_target    stored target on a hit, else 0
//   upd_valid      update strobe from the resolving stage
//   upd_pc         PC of the resolved branch
//   upd_taken      actual outcome
//   upd_target     resolved target address
//   upd_mispredict resolving stage saw a wrong prediction (statistics only)
//   flush_req      start invalidation sweep
//   busy           sweep in progress
//   stat_hits      lookup-hit cycle count
//   stat_mispred   accepted-mispredict count
// ---------------------------------------------------------------------------
module branch_target_buffer #(
    parameter int XLEN      = 64,
    parameter int N_ENTRIES = 16,
    parameter int TAG_BITS  = 8,
    parameter int CNT_BITS  = 2
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic [XLEN-1:0] IF_PC,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_mispredict,
    input  logic            flush_req,
    output logic            busy,
    output logic [31:0]     stat_hits,
    output logic [31:0]     stat_mispred
);

    localparam int IDX = $clog2(N_ENTRIES);

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    // Weakly-taken / weakly-not-taken states used when allocating an entry.
    localparam logic [CNT_BITS-1:0] WEAK_T  = CNT_BITS'(2 ** (CNT_BITS - 1));
    localparam logic [CNT_BITS-1:0] WEAK_N  = CNT_BITS'(2 ** (CNT_BITS - 1) - 1);
    localparam logic [IDX-1:0]      PTR_LAST = IDX'(N_ENTRIES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Table storage
    // ------------------------------------------------------------------
    logic [N_ENTRIES-1:0] valid_q;
    logic [TAG_BITS-1:0]  tag_q    [N_ENTRIES];
    logic [XLEN-1:0]      target_q [N_ENTRIES];
    logic [CNT_BITS-1:0]  cnt_q    [N_ENTRIES];

    state_t         state_q;
    state_t         state_d;
    logic [IDX-1:0] ptr_q;

    // FSM-derived controls
    logic idle;
    logic sweep_clr;

    // ------------------------------------------------------------------
    // Address decode. PC[1:0] and bits above the tag take no part.
    // ------------------------------------------------------------------
    logic [IDX-1:0]      lk_idx;
    logic [TAG_BITS-1:0] lk_tag;
    logic [IDX-1:0]      up_idx;
    logic [TAG_BITS-1:0] up_tag;

    assign lk_idx = IF_PC[IDX+1:2];
    assign lk_tag = IF_PC[IDX+TAG_BITS+1:IDX+2];
    assign up_idx = upd_pc[IDX+1:2];
    assign up_tag = upd_pc[IDX+TAG_BITS+1:IDX+2];

    logic unused_bits;
    assign unused_bits = ^{IF_PC, upd_pc, upd_mispredict};

    // ------------------------------------------------------------------
    // Lookup (combinational, no bypass from a same-cycle update)
    // ------------------------------------------------------------------
    logic lk_match;
    assign lk_match    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_hit    = idle && lk_match;
    assign pred_taken  = pred_hit && cnt_q[lk_idx][CNT_BITS-1];
    assign pred_target = pred_hit ? target_q[lk_idx] : '0;

    // ------------------------------------------------------------------
    // Update decode. Flush in the same idle cycle takes priority and the
    // update is dropped; updates during a sweep are dropped too.
    // ------------------------------------------------------------------
    logic                upd_accept;
    logic                upd_hit;
    logic [CNT_BITS-1:0] cnt_cur;
    logic [CNT_BITS-1:0] cnt_next;

    assign upd_accept = idle && upd_valid && !flush_req;
    assign upd_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign cnt_cur    = cnt_q[up_idx];

    always_comb begin
        cnt_next = cnt_cur;
        if (upd_taken) begin
            if (cnt_cur != CNT_MAX) cnt_next = cnt_cur + 1'b1;
        end else begin
            if (cnt_cur != '0) cnt_next = cnt_cur - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            valid_q <= '0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            if (sweep_clr) valid_q[ptr_q] <= 1'b0;
            if (upd_accept) begin
                if (upd_hit) begin
                    cnt_q[up_idx] <= cnt_next;
                    if (upd_taken) target_q[up_idx] <= upd_target;
                end else begin
                    // Allocate, overwriting any previous occupant.
                    valid_q[up_idx]  <= 1'b1;
                    tag_q[up_idx]    <= up_tag;
                    target_q[up_idx] <= upd_target;
                    cnt_q[up_idx]    <= upd_taken ? WEAK_T : WEAK_N;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sweep FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (flush_req) state_d = SWEEP;
            SWEEP:   if (ptr_q == PTR_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idle      = (state_q == IDLE);
        busy      = (state_q == SWEEP);
        sweep_clr = (state_q == SWEEP);
    end

    // Sweep pointer; wraps back to 0 after the last entry.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)                   ptr_q <= '0;
        else if (idle && flush_req)    ptr_q <= '0;
        else if (sweep_clr)            ptr_q <= ptr_q + 1'b1;
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef BTB_STATS_EN
    logic [31:0] hits_q;
    logic [31:0] misp_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            hits_q <= '0;
            misp_q <= '0;
        end else begin
            if (pred_hit && hits_q != 32'hFFFF_FFFF)
                hits_q <= hits_q + 32'd1;
            if (upd_accept && upd_mispredict && misp_q != 32'hFFFF_FFFF)
                misp_q <= misp_q + 32'd1;
        end
    end

    assign stat_hits    = hits_q;
    assign stat_mispred = misp_q;
`else
    assign stat_hits    = '0;
    assign stat_mispred = '0;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

    localparam int XLEN = 64;
    localparam int N    = 16;
    localparam int TAGB = 8;
    localparam int CNTB = 2;
    localparam int IDXB = 4;
    localparam int CMAX = (1 << CNTB) - 1;
    localparam int WT   = 1 << (CNTB - 1);

    logic            clk = 1'b0;
    logic            arst_n = 1'b0;
    logic [XLEN-1:0] IF_PC = '0;
    logic            pred_hit, pred_taken, busy;
    logic [XLEN-1:0] pred_target;
    logic            upd_valid = 1'b0, upd_taken = 1'b0, upd_mispredict = 1'b0;
    logic [XLEN-1:0] upd_pc = '0, upd_target = '0;
    logic            flush_req = 1'b0;
    logic [31:0]     stat_hits, stat_mispred;

    branch_target_buffer #(.XLEN(XLEN), .N_ENTRIES(N), .TAG_BITS(TAGB), .CNT_BITS(CNTB)) dut (
        .clk(clk), .arst_n(arst_n), .IF_PC(IF_PC),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .flush_req(flush_req), .busy(busy),
        .stat_hits(stat_hits), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    bit              mvalid [N];
    int              mtag   [N];
    logic [XLEN-1:0] mtarget[N];
    int              mcnt   [N];
    bit              msweep;
    int              mptr;
    longint          mhits, mmisp;

    function automatic int f_idx(logic [XLEN-1:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic int f_tag(logic [XLEN-1:0] pc);
        return int'((pc >> (2 + IDXB)) % (1 << TAGB));
    endfunction

    function automatic bit m_hit(logic [XLEN-1:0] pc);
        int i;
        i = f_idx(pc);
        return !msweep && mvalid[i] && (mtag[i] == f_tag(pc));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mvalid[i] = 0; mtag[i] = 0; mtarget[i] = '0; mcnt[i] = 0;
        end
        msweep = 0; mptr = 0; mhits = 0; mmisp = 0;
    endtask

    // Applies the effect of one rising edge given the current inputs.
    task automatic model_step();
        int i, t;
        if (m_hit(IF_PC) && mhits < 64'hFFFF_FFFF) mhits++;
        if (msweep) begin
            mvalid[mptr] = 0;
            if (mptr == N - 1) begin msweep = 0; mptr = 0; end
            else mptr++;
        end else if (flush_req) begin
            msweep = 1; mptr = 0;
        end else if (upd_valid) begin
            if (upd_mispredict) mmisp++;
            i = f_idx(upd_pc); t = f_tag(upd_pc);
            if (mvalid[i] && mtag[i] == t) begin
                if (upd_taken) begin
                    mcnt[i] = (mcnt[i] == CMAX) ? CMAX : mcnt[i] + 1;
                    mtarget[i] = upd_target;
                end else begin
                    mcnt[i] = (mcnt[i] == 0) ? 0 : mcnt[i] - 1;
                end
            end else begin
                mvalid[i] = 1; mtag[i] = t; mtarget[i] = upd_target;
                mcnt[i] = upd_taken ? WT : WT - 1;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(string tag, logic [XLEN-1:0] obs, logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all(string tag);
        bit h;
        int i;
        h = m_hit(IF_PC);
        i = f_idx(IF_PC);
        chk({tag, "_hit"}, pred_hit, h);
        chk({tag, "_taken"}, pred_taken, h && mcnt[i] >= WT);
        chk({tag, "_target"}, pred_target, h ? mtarget[i] : '0);
        chk({tag, "_busy"}, busy, msweep);
`ifdef BTB_STATS_EN
        chk({tag, "_shits"}, stat_hits, mhits[31:0]);
        chk({tag, "_smisp"}, stat_mispred, mmisp[31:0]);
`else
        chk({tag, "_shits"}, stat_hits, '0);
        chk({tag, "_smisp"}, stat_mispred, '0);
`endif
    endtask

    // One clock: check outputs at negedge against the model, then let the
    // edge happen and advance the model. Inputs change 1 time unit after it.
    task automatic cyc(string tag);
        @(negedge clk);
        cmp_all(tag);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_in();
        upd_valid = 0; upd_taken = 0; upd_mispredict = 0;
        upd_pc = '0; upd_target = '0; flush_req = 0;
    endtask

    task automatic upd(logic [XLEN-1:0] pc, bit tk, logic [XLEN-1:0] tgt, bit mp);
        upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_mispredict = mp;
    endtask

    task automatic do_reset();
        idle_in();
        arst_n = 0;
        #2;
        model_reset();
        cmp_all("rst");
        @(negedge clk);
        arst_n = 1;
        @(posedge clk);
        #1;
    endtask

    int busy_cnt;
    logic [XLEN-1:0] pc_r;

    initial begin
        model_reset();
        IF_PC = 64'h1000;
        do_reset();
        chk("rst_hit_direct", pred_hit, 1'b0);
        chk("rst_busy_direct", busy, 1'b0);

        // Allocate taken entry, visible on next cycle only
        upd(64'h1000, 1, 64'h2000, 0);
        cyc("alloc");
        idle_in();
        @(negedge clk);
        chk("alloc_hit", pred_hit, 1'b1);
        chk("alloc_taken", pred_taken, 1'b1);
        chk("alloc_target", pred_target, 64'h2000);
        @(posedge clk); model_step(); #1;

        // Three not-taken updates: 2 -> 1 -> 0 -> 0
        for (int k = 0; k < 3; k++) begin
            upd(64'h1000, 0, 64'h9999, 0);
            cyc("nt");
            idle_in();
            @(negedge clk);
            chk("nt_taken", pred_taken, 1'b0);
            chk("nt_target", pred_target, 64'h2000);
            @(posedge clk); model_step(); #1;
        end
        // One taken brings 0 -> 1: still predicts not-taken, target moves
        upd(64'h1000, 1, 64'h2400, 0);
        cyc("sat0");
        idle_in();
        @(negedge clk);
        chk("sat0_taken", pred_taken, 1'b0);
        chk("sat0_target", pred_target, 64'h2400);
        @(posedge clk); model_step(); #1;

        // Alias: same index, different tag replaces the entry
        upd(64'h1000 + 4 * N, 1, 64'h5000, 0);
        cyc("alias_upd");
        idle_in();
        IF_PC = 64'h1000;
        @(negedge clk);
        chk("alias_old_miss", pred_hit, 1'b0);
        @(posedge clk); model_step(); #1;
        IF_PC = 64'h1000 + 4 * N + 2;   // low bits ignored
        @(negedge clk);
        chk("alias_new_hit", pred_hit, 1'b1);
        chk("alias_new_tgt", pred_target, 64'h5000);
        @(posedge clk); model_step(); #1;

        // Back-to-back updates to one index
        upd(64'h1108, 1, 64'hA0, 0); cyc("b2b1");
        upd(64'h1108, 1, 64'hA4, 0); cyc("b2b2");
        upd(64'h1108, 0, 64'hA8, 0); cyc("b2b3");
        idle_in(); IF_PC = 64'h1108; cyc("b2b_chk");

        // Fill three entries, then sweep with a dropped mid-sweep update
        upd(64'h1104, 1, 64'h11, 0); cyc("fill1");
        upd(64'h1208, 0, 64'h22, 0); cyc("fill2");
        upd(64'h130C, 1, 64'h33, 0); cyc("fill3");
        idle_in();
        // Flush and update together: flush wins
        flush_req = 1;
        upd(64'h1410, 1, 64'h44, 0);
        cyc("flush");
        idle_in();
        busy_cnt = 0;
        for (int k = 0; k < 24; k++) begin
            if (k == 8) upd(64'h1104, 1, 64'h77, 0);
            if (k == 9) idle_in();
            if (k == 3) flush_req = 1;
            if (k == 4) flush_req = 0;
            IF_PC = 64'h1104;
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            cmp_all("sweep");
            @(posedge clk); model_step(); #1;
        end
        chk("sweep_len", busy_cnt, N);
        IF_PC = 64'h1104; @(negedge clk); chk("post_sweep_1104", pred_hit, 1'b0);
        IF_PC = 64'h1208; #1; chk("post_sweep_1208", pred_hit, 1'b0);
        IF_PC = 64'h130C; #1; chk("post_sweep_130c", pred_hit, 1'b0);
        IF_PC = 64'h1410; #1; chk("post_sweep_1410", pred_hit, 1'b0);
        @(posedge clk); model_step(); #1;

        // First hit possible on first idle cycle after sweep
        upd(64'h1500, 1, 64'h55, 0); cyc("refill");
        idle_in(); flush_req = 1; cyc("flush2");
        flush_req = 0;
        for (int k = 0; k < 5; k++) cyc("sweep2");
        // Reset during sweep cycle 5 aborts at once
        arst_n = 0;
        #1;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_hit", pred_hit, 1'b0);
        model_reset();
        @(negedge clk); arst_n = 1;
        @(posedge clk); #1;
        cyc("after_rst");

        // Statistics: 10 hit cycles and 3 mispredict updates
        do_reset();
        IF_PC = 64'h2000;
        upd(64'h1000, 1, 64'h2000, 0); cyc("st_alloc");
        idle_in();
        IF_PC = 64'h1000;
        for (int k = 0; k < 10; k++) begin
            if (k == 2 || k == 4 || k == 6) upd(64'h3004, 1, 64'h66, 1);
            else idle_in();
            cyc("st");
        end
        idle_in(); IF_PC = 64'h2000;
        @(negedge clk);
`ifdef BTB_STATS_EN
        chk("stat_hits10", stat_hits, 32'd10);
        chk("stat_misp3", stat_mispred, 32'd3);
`else
        chk("stat_hits0", stat_hits, 32'd0);
        chk("stat_misp0", stat_mispred, 32'd0);
`endif
        @(posedge clk); model_step(); #1;

        // Randomised traffic over a small PC pool so hits and aliasing occur
        for (int k = 0; k < 600; k++) begin
            pc_r = {$urandom, $urandom};
            pc_r[13:2] = {4'h0, 2'b0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, N - 1))};
            IF_PC = pc_r;
            if ($urandom_range(0, 1) == 1) begin
                pc_r = {$urandom, $urandom};
                pc_r[13:2] = {6'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, N - 1))};
                upd(pc_r, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            end else idle_in();
            flush_req = ($urandom_range(0, 59) == 0);
            cyc("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
